// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
//   Shared constants for the boot-time instruction loader: FSM state encoding
//   and default frame/image parameters.
// -----------------------------------------------------------------------------
package inst_loader_pkg;

    // FSM state encoding. Kept as plain constants so older tools and checkers
    // can compare against fixed codes.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN_L = 3'd1;
    localparam logic [2:0] ST_LEN_H = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned MAX_WORDS_DEFAULT = 1024;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// inst_loader_byte_packer
//   Packs four bytes into one little-endian 32-bit word.
//   Ports:
//     clk, rst_n   clock / asynchronous active-low reset
//     clear        return to byte 0 (frame start)
//     byte_valid   byte_data is accepted this cycle
//     byte_data    incoming byte, byte index b fills bits [8b+7:8b]
//     last_byte    the next accepted byte completes a word
//     word_valid   one-cycle pulse in the cycle after the 4th byte
//     word         last completed word; held until the next word completes
// -----------------------------------------------------------------------------
module inst_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] low_q;     // bytes 0..2 of the word being assembled

    assign last_byte = (byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= 2'd0;
            low_q      <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= 2'd0;
            end else if (byte_valid) begin
                case (byte_idx)
                    2'd0: low_q[7:0]   <= byte_data;
                    2'd1: low_q[15:8]  <= byte_data;
                    2'd2: low_q[23:16] <= byte_data;
                    default: begin
                        // Word register only changes on completion so the
                        // memory write data stays stable between strobes.
                        word       <= {byte_data, low_q};
                        word_valid <= 1'b1;
                    end
                endcase
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//   Boot-time program loader. Parses frames of the form
//     SYNC, LEN_L, LEN_H, LEN*4 data bytes (little-endian words), CSUM
//   writes each word to instruction memory with a one-cycle strobe and keeps
//   the core in reset until a frame with a matching checksum completes.
//   Ports:
//     clk, rst_n      clock / asynchronous active-low reset
//     rx_data/valid   byte stream in; transfer when rx_valid && rx_ready
//     rx_ready        low only during the single DONE cycle
//     inst_addr_load  write address (ADDR_BASE + 4*word index)
//     inst_load       write data
//     load_en         one-cycle write strobe
//     cpu_rst_n       core reset, released the cycle after DONE
//     busy            frame in progress (LEN_L, LEN_H, DATA, CSUM)
//     done / err      sticky frame outcome, cleared by the next sync
//     words_loaded    words written in the current or last frame
//
//   Handshake: a byte moves exactly on a rising edge where rx_valid and
//   rx_ready are both high; rx_ready does not depend on rx_valid.
// -----------------------------------------------------------------------------
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter logic [31:0]  ADDR_BASE = 32'h0000_0000,
    parameter int unsigned  MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter logic [7:0]   SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] inst_addr_load,
    output logic [31:0] inst_load,
    output logic        load_en,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    logic [2:0]  state;
    logic [15:0] len_q;
    logic [7:0]  csum_q;

    logic        accept;
    logic        is_sync;
    logic        sync_hit;
    logic        data_accept;
    logic        last_byte;
    logic [15:0] len_full;

    assign rx_ready    = (state != ST_DONE);
    assign busy        = (state == ST_LEN_L) || (state == ST_LEN_H) ||
                         (state == ST_DATA)  || (state == ST_CSUM);
    assign accept      = rx_valid && rx_ready;
    assign is_sync     = (rx_data == SYNC_BYTE);
    // Sync only starts a frame from IDLE or ERR; inside DATA it is payload.
    assign sync_hit    = accept && is_sync &&
                         ((state == ST_IDLE) || (state == ST_ERR));
    assign data_accept = accept && (state == ST_DATA);
    assign len_full    = {rx_data, len_q[7:0]};

    inst_loader_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (sync_hit),
        .byte_valid (data_accept),
        .byte_data  (rx_data),
        .last_byte  (last_byte),
        .word_valid (load_en),
        .word       (inst_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            len_q          <= 16'd0;
            csum_q         <= 8'd0;
            done           <= 1'b0;
            err            <= 1'b0;
            cpu_rst_n      <= 1'b0;
            words_loaded   <= 16'd0;
            inst_addr_load <= ADDR_BASE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && is_sync) state <= ST_LEN_L;
                end
                ST_LEN_L: begin
                    if (accept) begin
                        len_q[7:0] <= rx_data;
                        state      <= ST_LEN_H;
                    end
                end
                ST_LEN_H: begin
                    if (accept) begin
                        len_q[15:8] <= rx_data;
                        if ({16'd0, len_full} > MAX_WORDS) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum_q <= csum_q + rx_data;
                        if (last_byte) begin
                            // Registered together with the packer strobe, so
                            // the address seen with load_en is the
                            // pre-increment word index.
                            inst_addr_load <= ADDR_BASE + {14'd0, words_loaded, 2'b00};
                            words_loaded   <= words_loaded + 16'd1;
                            if (words_loaded + 16'd1 == len_q) state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum_q) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    cpu_rst_n <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_ERR: begin
                    if (accept && is_sync) state <= ST_LEN_L;
                end
                default: state <= ST_IDLE;
            endcase

            // New frame: forget the previous outcome and hold the core again.
            if (sync_hit) begin
                done         <= 1'b0;
                err          <= 1'b0;
                words_loaded <= 16'd0;
                csum_q       <= 8'd0;
                cpu_rst_n    <= 1'b0;
            end
        end
    end

endmodule
